// File: rtl/adder_kogge_pkg.sv
// Shared definitions for the instrumented Kogge-Stone adder wrapper.
//   - Geometry: adder width, Caravel GPIO count and the two GPIO indices in use.
//   - Control word layout on la3_data_in (register select, write, run, clear).
//   - Status word layout on la3_data_out.
package adder_kogge_pkg;

  localparam int WIDTH    = 32;  // adder, operand and mask width (LA buses are 32 bits)
  localparam int IO_W     = 38;  // Caravel GPIO count
  localparam int CHAIN_IO = 9;   // GPIO driven by chain_out
  localparam int EXT_IO   = 8;   // GPIO sampled as external stimulus

  // Register select field, la3_data_in[2:0]. Codes 5..7 are ignored.
  typedef enum logic [2:0] {
    SEL_A     = 3'd0,  // a_input
    SEL_B     = 3'd1,  // b_input
    SEL_RING  = 3'd2,  // ring feedback mask
    SEL_EXT   = 3'd3,  // external stimulus mask
    SEL_SMASK = 3'd4   // sum tap mask
  } sel_e;

  // Control word bit positions.
  localparam int CTL_SEL_LSB = 0;
  localparam int CTL_WR      = 3;
  localparam int CTL_RUN     = 4;
  localparam int CTL_CLR     = 5;

  // Status word bit positions; all other bits read 0.
  localparam int ST_CHAIN = 0;
  localparam int ST_COUT  = 1;
  localparam int ST_EXT   = 2;
  localparam int ST_RUN   = 3;

endpackage

// File: rtl/kogge_stone_adder32.sv
// 32-bit adder with carry in / carry out.
//   a, b : operands          cin  : carry in
//   sum  : a + b + cin       cout : carry out of the top bit
// Build option KOGGE_STONE_EN selects an explicit Kogge-Stone parallel prefix
// network (5 levels, strides 1/2/4/8/16); without it the adder is a plain "+".
// Both variants produce identical results.
module kogge_stone_adder32
  import adder_kogge_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

`ifdef KOGGE_STONE_EN
  localparam int LEVELS = 5;  // log2(WIDTH)

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_lvl [LEVELS+1];
  logic [WIDTH-1:0] p_lvl [LEVELS+1];

  assign p_bit = a ^ b;

  // Folding cin into bit 0's generate makes every group generate at the last
  // level equal to the carry into the next bit, so no separate carry tree.
  assign g_lvl[0] = {a[WIDTH-1:1] & b[WIDTH-1:1], (a[0] & b[0]) | (p_bit[0] & cin)};
  assign p_lvl[0] = p_bit;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int STRIDE = 1 << l;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= STRIDE) begin : g_combine
        assign g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-STRIDE]);
        assign p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-STRIDE];
      end else begin : g_pass
        assign g_lvl[l+1][i] = g_lvl[l][i];
        assign p_lvl[l+1][i] = p_lvl[l][i];
      end
    end
  end

  assign sum  = p_bit ^ {g_lvl[LEVELS][WIDTH-2:0], cin};
  assign cout = g_lvl[LEVELS][WIDTH-1];
`else
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
`endif

endmodule

// File: rtl/wrapped_instrumented_adder_kogge.sv
// Caravel user-project wrapper: 32-bit adder instrumented as a clocked pseudo
// ring oscillator for delay characterisation.
//   wb_clk_i, wb_rst_n : clock, async active-low reset
//   active             : wrapper select; 0 forces all outputs to 0, io_oeb to 1
//   la1_data_in        : write data for operand/mask registers
//   la1_data_out       : registered sum
//   la2_data_out       : chain rising-edge counter (saturating)
//   la3_data_in        : control {clr, run, wr, sel[2:0]}
//   la3_data_out       : status {run, ext_s, cout, chain_out}
//   io_in[EXT_IO]      : external stimulus (synchronised)
//   io_out[CHAIN_IO]   : chain_out; io_oeb low only on that pin when active
//   la*_oenb, la2_data_in : unused
// Build option KOGGE_STONE_EN selects the explicit prefix-network adder.
module wrapped_instrumented_adder_kogge
  import adder_kogge_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             active,
  input  logic [WIDTH-1:0] la1_data_in,
  output logic [WIDTH-1:0] la1_data_out,
  input  logic [WIDTH-1:0] la1_oenb,
  input  logic [WIDTH-1:0] la2_data_in,
  output logic [WIDTH-1:0] la2_data_out,
  input  logic [WIDTH-1:0] la2_oenb,
  input  logic [WIDTH-1:0] la3_data_in,
  output logic [WIDTH-1:0] la3_data_out,
  input  logic [WIDTH-1:0] la3_oenb,
  input  logic [IO_W-1:0]  io_in,
  output logic [IO_W-1:0]  io_out,
  output logic [IO_W-1:0]  io_oeb
);

  logic [2:0]       sel;
  logic             wr, run, clr;
  logic [WIDTH-1:0] a_input, b_input;
  logic [WIDTH-1:0] a_input_ring_bit_b, a_input_ext_bit_b, s_output_bit_b;
  logic             ext_meta, ext_s;
  logic             chain_out, chain_next;
  logic [WIDTH-1:0] a_eff, sum, sum_q, counter;
  logic             cout, cout_q, run_q;
  logic             unused_inputs;

  assign sel = la3_data_in[CTL_SEL_LSB +: 3];
  assign wr  = la3_data_in[CTL_WR];
  assign run = la3_data_in[CTL_RUN];
  assign clr = la3_data_in[CTL_CLR];

  assign unused_inputs = ^{la1_oenb, la2_data_in, la2_oenb, la3_oenb,
                           la3_data_in[WIDTH-1:CTL_CLR+1],
                           io_in[IO_W-1:EXT_IO+1], io_in[EXT_IO-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_input            <= '0;
      b_input            <= '0;
      a_input_ring_bit_b <= '0;
      a_input_ext_bit_b  <= '0;
      s_output_bit_b     <= '0;
    end else if (wr) begin
      case (sel)
        SEL_A:     a_input            <= la1_data_in;
        SEL_B:     b_input            <= la1_data_in;
        SEL_RING:  a_input_ring_bit_b <= la1_data_in;
        SEL_EXT:   a_input_ext_bit_b  <= la1_data_in;
        SEL_SMASK: s_output_bit_b     <= la1_data_in;
        default:   ;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
    end else begin
      ext_meta <= io_in[EXT_IO];
      ext_s    <= ext_meta;
    end
  end

  // Ring bits take the inverted chain; ext bits (not also ring) take ext_s.
  assign a_eff = (a_input & ~a_input_ring_bit_b & ~a_input_ext_bit_b)
               | (a_input_ring_bit_b & {WIDTH{~chain_out}})
               | (a_input_ext_bit_b & ~a_input_ring_bit_b & {WIDTH{ext_s}});

  kogge_stone_adder32 u_adder (
    .a    (a_eff),
    .b    (b_input),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign chain_next = run & |(sum & s_output_bit_b);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      chain_out <= 1'b0;
      run_q     <= 1'b0;
      counter   <= '0;
    end else begin
      sum_q     <= sum;
      cout_q    <= cout;
      chain_out <= chain_next;
      run_q     <= run;
      if (clr)
        counter <= '0;
      else if (run && !chain_out && chain_next && counter != '1)
        counter <= counter + 32'd1;
    end
  end

  // NOTE: every output gets a default before the conditional overrides so the
  // block stays purely combinational with no inferred latch.
  always_comb begin
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    io_out       = '0;
    io_oeb       = '1;
    if (active) begin
      la1_data_out           = sum_q;
      la2_data_out           = counter;
      la3_data_out[ST_CHAIN] = chain_out;
      la3_data_out[ST_COUT]  = cout_q;
      la3_data_out[ST_EXT]   = ext_s;
      la3_data_out[ST_RUN]   = run_q;
      io_out[CHAIN_IO]       = chain_out;
      io_oeb[CHAIN_IO]       = 1'b0;
    end
  end

endmodule

// File: tb/tb_wrapped_instrumented_adder_kogge.sv
// Self-checking bench for wrapped_instrumented_adder_kogge. Inputs change on the
// falling clock edge and outputs are sampled there, half a cycle from capture.
module tb_wrapped_instrumented_adder_kogge;
  import adder_kogge_pkg::*;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_n;
  logic             active;
  logic [WIDTH-1:0] la1_data_in, la1_data_out, la1_oenb;
  logic [WIDTH-1:0] la2_data_in, la2_data_out, la2_oenb;
  logic [WIDTH-1:0] la3_data_in, la3_data_out, la3_oenb;
  logic [IO_W-1:0]  io_in, io_out, io_oeb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  logic run_bit = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  wrapped_instrumented_adder_kogge dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_n     (wb_rst_n),
    .active       (active),
    .la1_data_in  (la1_data_in),
    .la1_data_out (la1_data_out),
    .la1_oenb     (la1_oenb),
    .la2_data_in  (la2_data_in),
    .la2_data_out (la2_data_out),
    .la2_oenb     (la2_oenb),
    .la3_data_in  (la3_data_in),
    .la3_data_out (la3_data_out),
    .la3_oenb     (la3_oenb),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed=0x%0h expected=<none>", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge wb_clk_i);
  endtask

  function automatic logic [31:0] ctl(input logic [2:0] sel, input logic wr,
                                      input logic run, input logic clr);
    logic [31:0] w;
    w = '0;
    w[CTL_SEL_LSB +: 3] = sel;
    w[CTL_WR]  = wr;
    w[CTL_RUN] = run;
    w[CTL_CLR] = clr;
    return w;
  endfunction

  task automatic wr_reg(input logic [2:0] sel, input logic [31:0] data);
    la1_data_in = data;
    la3_data_in = ctl(sel, 1'b1, run_bit, 1'b0);
    tick();
    la3_data_in = ctl(3'd0, 1'b0, run_bit, 1'b0);
  endtask

  task automatic start_run_clear();
    run_bit     = 1'b1;
    la3_data_in = ctl(3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    la3_data_in = ctl(3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a, b, s;
    logic        c;
    logic        exp_chain;
    int          exp_cnt;

    wb_rst_n    = 1'b0;
    active      = 1'b1;
    la1_data_in = '0;
    la1_oenb    = '1;
    la2_data_in = '0;
    la2_oenb    = '1;
    la3_data_in = '0;
    la3_oenb    = '1;
    io_in       = '0;

    // Reset state
    tick(2);
    check("rst_la1", la1_data_out, 64'h0);
    check("rst_la2", la2_data_out, 64'h0);
    check("rst_la3", la3_data_out, 64'h0);
    check("rst_io_out", io_out, 64'h0);
    check("rst_io_oeb", io_oeb, {26'h0, {IO_W{1'b1}} & ~(38'd1 << CHAIN_IO)});
    wb_rst_n = 1'b1;
    tick();

    // Basic add: carry ripples across the low half
    wr_reg(SEL_A, 32'h0000_FFFF);
    wr_reg(SEL_B, 32'h0000_0001);
    sb_push("add_sum", 64'h0001_0000);
    sb_push("add_status", 64'h0);
    tick();
    sb_pop(la1_data_out);
    sb_pop(la3_data_out);

    // Random operands against a 33-bit reference sum
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      b = $urandom();
      {c, s} = {1'b0, a} + {1'b0, b};
      wr_reg(SEL_A, a);
      wr_reg(SEL_B, b);
      sb_push($sformatf("rnd%0d_sum", i), {32'h0, s});
      sb_push($sformatf("rnd%0d_status", i), {62'h0, c, 1'b0});
      tick();
      sb_pop(la1_data_out);
      sb_pop(la3_data_out);
    end

    // Overflow: sum wraps to 0, carry out set
    wr_reg(SEL_A, 32'hFFFF_FFFF);
    wr_reg(SEL_B, 32'h0000_0001);
    sb_push("ovf_sum", 64'h0);
    sb_push("ovf_status", 64'h2);
    tick();
    sb_pop(la1_data_out);
    sb_pop(la3_data_out);

    // Reserved select codes must not disturb any register
    wr_reg(3'd5, 32'h1234_5678);
    wr_reg(3'd7, 32'h8765_4321);
    sb_push("sel_ign_sum", 64'h0);
    sb_push("sel_ign_status", 64'h2);
    tick();
    sb_pop(la1_data_out);
    sb_pop(la3_data_out);

    // Ring oscillator on bit 0
    wr_reg(SEL_A, 32'h0);
    wr_reg(SEL_B, 32'h0);
    wr_reg(SEL_RING, 32'h1);
    wr_reg(SEL_SMASK, 32'h1);
    tick();
    check("ring_idle_sum", la1_data_out, 64'h1);
    check("ring_idle_status", la3_data_out, 64'h0);

    start_run_clear();
    exp_chain = 1'b1;
    exp_cnt   = 0;
    check("ring_start_status", la3_data_out, {60'h0, 1'b1, 2'b00, exp_chain});
    check("ring_start_cnt", la2_data_out, 64'(exp_cnt));
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_chain = ~exp_chain;
      if (exp_chain) exp_cnt++;
      check($sformatf("ring_status_c%0d", i), la3_data_out, {60'h0, 1'b1, 2'b00, exp_chain});
    end
    check("ring_cnt20", la2_data_out, 64'(exp_cnt));

    // Stop: chain drops next cycle, count holds
    run_bit     = 1'b0;
    la3_data_in = ctl(3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("ring_stop_status", la3_data_out, 64'h0);
    tick(3);
    check("ring_stop_hold", la2_data_out, 64'(exp_cnt));

    // External stimulus on bit 0
    wr_reg(SEL_RING, 32'h0);
    wr_reg(SEL_EXT, 32'h1);
    start_run_clear();
    exp_cnt = 0;
    check("ext_clr_cnt", la2_data_out, 64'h0);
    io_in[EXT_IO] = 1'b1;
    tick();
    check("ext_lat1_status", la3_data_out, 64'h8);
    tick();
    check("ext_lat2_status", la3_data_out, 64'hC);
    tick();
    exp_cnt++;
    check("ext_lat3_status", la3_data_out, 64'hD);
    check("ext_lat3_cnt", la2_data_out, 64'(exp_cnt));
    for (int k = 0; k < 3; k++) begin
      io_in[EXT_IO] = 1'b0;
      tick(4);
      io_in[EXT_IO] = 1'b1;
      tick(4);
      exp_cnt++;
      check($sformatf("ext_edge%0d_cnt", k), la2_data_out, 64'(exp_cnt));
    end

    // Gating: outputs off, internal counting continues
    active = 1'b0;
    #1;
    check("gate_la1", la1_data_out, 64'h0);
    check("gate_la2", la2_data_out, 64'h0);
    check("gate_la3", la3_data_out, 64'h0);
    check("gate_io_out", io_out, 64'h0);
    check("gate_io_oeb", io_oeb, {26'h0, {IO_W{1'b1}}});
    tick();
    io_in[EXT_IO] = 1'b0;
    tick(4);
    io_in[EXT_IO] = 1'b1;
    tick(4);
    exp_cnt++;
    check("gate_off_la2", la2_data_out, 64'h0);
    active = 1'b1;
    #1;
    check("gate_on_cnt", la2_data_out, 64'(exp_cnt));
    check("gate_on_io_out", io_out, 64'(38'd1 << CHAIN_IO));
    check("gate_on_io_oeb", io_oeb, {26'h0, {IO_W{1'b1}} & ~(38'd1 << CHAIN_IO)});
    tick();
    io_in[EXT_IO] = 1'b0;
    tick(4);
    io_in[EXT_IO] = 1'b1;
    tick(4);
    exp_cnt++;
    check("gate_on_advance", la2_data_out, 64'(exp_cnt));

    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
